// File: rtl/jt900h_dump_pkg.sv
// Shared types and constants for the jt900h run/stop controller and register dump.
package jt900h_dump_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dump_state_e;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_STOP = 2'd1;
  localparam logic [1:0] CAUSE_WDOG = 2'd2;
  localparam logic [1:0] CAUSE_HALT = 2'd3;

  localparam int DUMP_LEN_DEFAULT = 84;

  // Byte offsets of the register file sections inside the dump
  localparam int XREG_BASE  = 0;
  localparam int INDEX_BASE = 64;
  localparam int SR_OFS     = 80;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/jt900h_dump_buf.sv
// 256x8 capture buffer: one synchronous write port, asynchronous read, no reset.
module jt900h_dump_buf (
  input  logic       clk,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [256];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jt900h_dumpctl.sv
// Run/stop controller: divides the CPU clock enable, detects stop causes and
// sweeps the CPU dump port into a readable capture buffer.
module jt900h_dumpctl
  import jt900h_dump_pkg::*;
#(
  parameter int            AW        = 24,
  parameter logic [AW-1:0] STOP_ADDR = AW'(24'h00ffff),
  parameter int            DUMP_LEN  = DUMP_LEN_DEFAULT,
  parameter int            CEN_DIV   = 1,
  parameter int            TOW       = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ram_addr,
  input  logic [1:0]    ram_we,
  input  logic          halt_req,
  output logic          cen,
  output logic [7:0]    dmp_addr,
  input  logic [7:0]    dmp_din,
  input  logic [7:0]    rd_addr,
  output logic [7:0]    rd_data,
  output logic          done,
  output logic [1:0]    cause,
  output logic [31:0]   run_cycles
);

  localparam logic [7:0] LAST_ADDR = 8'(DUMP_LEN);
  localparam logic [3:0] PH_LAST   = 4'(CEN_DIV - 1);

  dump_state_e     state_q, state_d;
  logic [3:0]      phase_q, phase_d;
  logic [TOW-1:0]  wdog_q, wdog_d;
  logic [31:0]     cycles_q, cycles_d;
  logic [1:0]      cause_q, cause_d;
  logic [7:0]      dmp_addr_q, dmp_addr_d;
  logic            cen_q, cen_d;

  logic            stop_wr, wdog_hit, stop_any;
  logic [1:0]      stop_cause;
  logic            buf_we;
  logic [7:0]      buf_waddr, buf_rdata;

  // Stop sources are sampled every clk, independent of the enable phase
  always_comb begin
    stop_wr  = ram_we[1] && (ram_addr == STOP_ADDR);
    wdog_hit = &wdog_q;
    stop_any = stop_wr || halt_req || wdog_hit;
    if (stop_wr)       stop_cause = CAUSE_STOP;
    else if (halt_req) stop_cause = CAUSE_HALT;
    else if (wdog_hit) stop_cause = CAUSE_WDOG;
    else               stop_cause = CAUSE_NONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (stop_any) state_d = DUMP;
      DUMP:    if (dmp_addr_q == LAST_ADDR) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    done      = (state_q == DONE);
    buf_we    = (state_q == DUMP) && (dmp_addr_q != 8'd0);
    buf_waddr = dmp_addr_q - 8'd1;
  end

  // The enable is registered so it reads 0 in reset and rises on the first edge after it
  always_comb begin
    phase_d    = phase_q;
    wdog_d     = wdog_q;
    cycles_d   = cycles_q;
    cause_d    = cause_q;
    dmp_addr_d = dmp_addr_q;
    cen_d      = 1'b0;
    case (state_q)
      RUN: begin
        phase_d = (phase_q == PH_LAST) ? 4'd0 : phase_q + 4'd1;
        if (cen_q) begin
          wdog_d   = wdog_q + TOW'(1);
          cycles_d = sat_inc32(cycles_q);
        end
        if (stop_any) begin
          cause_d    = stop_cause;
          dmp_addr_d = 8'd0;
        end else begin
          cen_d = (phase_q == 4'd0);
        end
      end
      DUMP: begin
        if (dmp_addr_q != LAST_ADDR) dmp_addr_d = dmp_addr_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= 4'd0;
      wdog_q     <= '0;
      cycles_q   <= 32'd0;
      cause_q    <= CAUSE_NONE;
      dmp_addr_q <= 8'd0;
      cen_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      wdog_q     <= wdog_d;
      cycles_q   <= cycles_d;
      cause_q    <= cause_d;
      dmp_addr_q <= dmp_addr_d;
      cen_q      <= cen_d;
    end
  end

  jt900h_dump_buf u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (dmp_din),
    .raddr_i (rd_addr),
    .rdata_o (buf_rdata)
  );

  assign rd_data    = (rd_addr < LAST_ADDR) ? buf_rdata : 8'd0;
  assign cen        = cen_q;
  assign dmp_addr   = dmp_addr_q;
  assign cause      = cause_q;
  assign run_cycles = cycles_q;

endmodule

// File: tb/tb_jt900h_dumpctl.sv
// Randomized bench: two controllers (divide-by-1 and divide-by-3 with a short
// watchdog) checked every clk against a closed-form model of the run/dump timeline.
module tb_jt900h_dumpctl;
  import jt900h_dump_pkg::*;

  localparam int          NI    = 2;
  localparam logic [23:0] STOP  = 24'h00ffff;
  localparam int          L     = 84;
  localparam int          TOW_A = 20;
  localparam int          TOW_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]        rst_n;
  logic [NI-1:0][23:0]  ram_addr;
  logic [NI-1:0][1:0]   ram_we;
  logic [NI-1:0]        halt_req;
  logic [NI-1:0]        cen;
  logic [NI-1:0][7:0]   dmp_addr;
  logic [NI-1:0][7:0]   dmp_din;
  logic [NI-1:0][7:0]   rd_addr;
  logic [NI-1:0][7:0]   rd_data;
  logic [NI-1:0]        done;
  logic [NI-1:0][1:0]   cause;
  logic [NI-1:0][31:0]  run_cycles;

  logic [7:0] cpu_mem [NI][256];

  int n_vec;
  int n_miss;

  int         m_e     [NI];
  int         m_s     [NI];
  bit         m_stop  [NI];
  logic [1:0] m_cause [NI];
  longint     m_rc    [NI];

  jt900h_dumpctl #(.AW(24), .STOP_ADDR(STOP), .DUMP_LEN(L), .CEN_DIV(1), .TOW(TOW_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n[0]), .ram_addr(ram_addr[0]), .ram_we(ram_we[0]),
    .halt_req(halt_req[0]), .cen(cen[0]), .dmp_addr(dmp_addr[0]), .dmp_din(dmp_din[0]),
    .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .done(done[0]), .cause(cause[0]),
    .run_cycles(run_cycles[0])
  );

  jt900h_dumpctl #(.AW(24), .STOP_ADDR(STOP), .DUMP_LEN(L), .CEN_DIV(3), .TOW(TOW_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n[1]), .ram_addr(ram_addr[1]), .ram_we(ram_we[1]),
    .halt_req(halt_req[1]), .cen(cen[1]), .dmp_addr(dmp_addr[1]), .dmp_din(dmp_din[1]),
    .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .done(done[1]), .cause(cause[1]),
    .run_cycles(run_cycles[1])
  );

  // CPU dump port: registered read of the register-file image
  always @(posedge clk) begin
    dmp_din[0] <= cpu_mem[0][dmp_addr[0]];
    dmp_din[1] <= cpu_mem[1][dmp_addr[1]];
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic longint wd_max(input int i);
    return (i == 0) ? ((longint'(1) << TOW_A) - 1) : ((longint'(1) << TOW_B) - 1);
  endfunction

  // Enabled cycles completed by edge ev: cen is high after edges 1, 1+N, 1+2N, ...
  function automatic longint rc_of(input int i, input int ev);
    return (ev >= 2) ? longint'((ev - 2) / div_of(i) + 1) : longint'(0);
  endfunction

  function automatic string nm(input int i);
    return (i == 0) ? "a" : "b";
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic mdl_clear(input int i);
    m_e[i]     = 0;
    m_s[i]     = 0;
    m_stop[i]  = 1'b0;
    m_cause[i] = CAUSE_NONE;
    m_rc[i]    = 0;
  endtask

  task automatic mdl_edge(input int i);
    bit sw, wd;
    if (!rst_n[i]) begin
      mdl_clear(i);
    end else begin
      m_e[i]++;
      if (!m_stop[i]) begin
        sw = ram_we[i][1] && (ram_addr[i] == STOP);
        wd = rc_of(i, m_e[i] - 1) >= wd_max(i);
        if (sw || halt_req[i] || wd) begin
          m_stop[i]  = 1'b1;
          m_s[i]     = m_e[i];
          m_cause[i] = sw ? CAUSE_STOP : (halt_req[i] ? CAUSE_HALT : CAUSE_WDOG);
          m_rc[i]    = rc_of(i, m_e[i]);
          $display("[%0t] %s: stop at edge %0d cause=%0d run_cycles=%0d",
                   $time, nm(i), m_e[i], m_cause[i], m_rc[i]);
        end
      end
    end
  endtask

  task automatic check_outputs(input int i);
    logic [63:0] ecen, ecause, edone, edmp, erc;
    int d;
    if (!m_stop[i]) begin
      ecen   = (m_e[i] >= 1 && ((m_e[i] - 1) % div_of(i)) == 0) ? 64'd1 : 64'd0;
      ecause = 64'(CAUSE_NONE);
      edone  = 64'd0;
      edmp   = 64'd0;
      erc    = 64'(rc_of(i, m_e[i]));
    end else begin
      d      = m_e[i] - m_s[i];
      ecen   = 64'd0;
      ecause = 64'(m_cause[i]);
      edmp   = (d < L) ? 64'(d) : 64'(L);
      edone  = (d >= L + 1) ? 64'd1 : 64'd0;
      erc    = 64'(m_rc[i]);
    end
    chk({nm(i), ".cen"},        64'(cen[i]),        ecen);
    chk({nm(i), ".cause"},      64'(cause[i]),      ecause);
    chk({nm(i), ".done"},       64'(done[i]),       edone);
    chk({nm(i), ".dmp_addr"},   64'(dmp_addr[i]),   edmp);
    chk({nm(i), ".run_cycles"}, 64'(run_cycles[i]), erc);
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < NI; i++) mdl_edge(i);
    #1;
    for (int i = 0; i < NI; i++) check_outputs(i);
  endtask

  task automatic do_reset(input int i);
    rst_n[i] = 1'b0;
    #1;
    mdl_clear(i);
    check_outputs(i);
  endtask

  // Random bus traffic; near-miss writes (low byte at STOP, high byte next door) are common
  task automatic drive(input int i, input bit allow_stop, input bit allow_halt);
    int r;
    r = $urandom_range(0, 3);
    case (r)
      0: begin ram_addr[i] = STOP;         ram_we[i] = 2'b01; end
      1: begin ram_addr[i] = STOP - 24'd1; ram_we[i] = 2'b10; end
      2: begin
        ram_addr[i] = 24'($urandom);
        ram_we[i]   = 2'($urandom);
        if (!allow_stop && ram_addr[i] == STOP) ram_we[i][1] = 1'b0;
      end
      default: begin
        ram_addr[i] = allow_stop ? STOP : 24'($urandom);
        ram_we[i]   = allow_stop ? 2'b10 : 2'b00;
      end
    endcase
    halt_req[i] = allow_halt ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic sweep_read();
    logic [7:0] exp_b;
    for (int k = 0; k <= 90; k++) begin
      for (int i = 0; i < NI; i++) begin
        rd_addr[i] = 8'(k);
        drive(i, 1'b1, 1'b1);
      end
      step();
      for (int i = 0; i < NI; i++) begin
        exp_b = (k < L) ? cpu_mem[i][k] : 8'd0;
        chk($sformatf("%s.rd[%0d]", nm(i), k), 64'(rd_data[i]), 64'(exp_b));
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    for (int i = 0; i < NI; i++) begin
      rst_n[i]    = 1'b0;
      rd_addr[i]  = 8'd0;
      ram_addr[i] = 24'd0;
      ram_we[i]   = 2'b00;
      halt_req[i] = 1'b0;
      for (int k = 0; k < 256; k++) cpu_mem[i][k] = 8'($urandom);
      mdl_clear(i);
    end

    repeat (3) step();
    rst_n = '1;

    // a: stop write sampled on edge 101; b: watchdog runs out
    repeat (100) begin
      drive(0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0);
      step();
    end
    ram_addr[0] = STOP; ram_we[0] = 2'b10; halt_req[0] = 1'b0;
    drive(1, 1'b0, 1'b0);
    step();
    chk("a.stop_cause", 64'(cause[0]), 64'(CAUSE_STOP));
    chk("a.stop_rc", 64'(run_cycles[0]), 64'd100);

    repeat (84) begin
      drive(0, 1'b1, 1'b1);
      drive(1, 1'b1, 1'b1);
      step();
    end
    chk("a.done_early", 64'(done[0]), 64'd0);
    drive(0, 1'b1, 1'b1);
    drive(1, 1'b1, 1'b1);
    step();
    chk("a.done_85", 64'(done[0]), 64'd1);
    chk("b.wdog_cause", 64'(cause[1]), 64'(CAUSE_WDOG));
    chk("b.wdog_rc", 64'(run_cycles[1]), 64'd15);

    sweep_read();

    // Restart both; b stops on halt_req, a sees near misses then a stop+halt collision
    do_reset(0);
    do_reset(1);
    repeat (2) step();
    rst_n = '1;
    for (int n = 0; n < 50; n++) begin
      drive(0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0);
      if (n == 20) halt_req[1] = 1'b1;
      step();
    end
    chk("a.no_stop", 64'(cause[0]), 64'(CAUSE_NONE));
    chk("b.halt_cause", 64'(cause[1]), 64'(CAUSE_HALT));

    ram_addr[0] = STOP; ram_we[0] = 2'b10; halt_req[0] = 1'b1;
    drive(1, 1'b1, 1'b1);
    step();
    chk("a.prio", 64'(cause[0]), 64'(CAUSE_STOP));
    repeat (40) begin
      drive(0, 1'b0, 1'b1);
      drive(1, 1'b1, 1'b1);
      step();
    end
    chk("a.dmp40", 64'(dmp_addr[0]), 64'd40);
    chk("a.cause_kept", 64'(cause[0]), 64'(CAUSE_STOP));

    // Abort mid-dump, load a new register image and dump again
    do_reset(0);
    for (int k = 0; k < 256; k++) cpu_mem[0][k] = 8'($urandom);
    repeat (2) begin
      drive(1, 1'b1, 1'b1);
      step();
    end
    rst_n[0] = 1'b1;
    repeat (20) begin
      drive(0, 1'b0, 1'b0);
      drive(1, 1'b1, 1'b1);
      step();
    end
    ram_addr[0] = STOP; ram_we[0] = 2'b10; halt_req[0] = 1'b0;
    drive(1, 1'b1, 1'b1);
    step();
    chk("a.restart_dmp", 64'(dmp_addr[0]), 64'd0);
    repeat (85) begin
      drive(0, 1'b1, 1'b1);
      drive(1, 1'b1, 1'b1);
      step();
    end
    chk("a.redone", 64'(done[0]), 64'd1);

    sweep_read();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
